// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: multi-digit BCD adder/subtractor, one digit per clock,
// least-significant digit first, reusing a single corrected 4-bit digit adder.
//
// Ports:
//   Clk, Rst        clock (rising edge), asynchronous active-high reset
//   start           begin an operation (only honoured while busy=0)
//   sub, cin        mode (0 add / 1 subtract) and carry/borrow-in, latched with start
//   a, b            operands, digit i at [4i+3:4i]
//   busy            operation in progress
//   done            one-cycle pulse when sum/cout/invalid update
//   sum, cout       BCD result and decimal carry-out (subtract: 1 = no borrow)
//   invalid         an operand digit was above 9; sum/cout forced to 0

module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);
  logic [3:0] bd;
  logic [4:0] t;

  always_comb begin
    // Subtract is A + (9 - B) + carry: nine's complement plus the carry chain
    // gives ten's-complement arithmetic across all digits.
    bd = sub ? (4'd9 - b) : b;
    t  = {1'b0, a} + {1'b0, bd} + {4'b0, cin};
    if (t > 5'd9) begin
      digit = t[3:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = t[3:0];
      cout  = 1'b0;
    end
  end
endmodule

module bcd_serial_addsub #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(DIGITS) + 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [DIGITS-1:0][3:0] a_p, b_p;
  logic [DIGITS-1:0][3:0] a_q, b_q, shadow, shadow_nx;
  logic                   sub_q, c_q, inv_q, inv_in;
  logic [CNT_W-1:0]       idx;
  logic                   last;
  logic [3:0]             a_d, b_d, dig;
  logic                   dig_c;

  assign a_p  = a;
  assign b_p  = b;
  assign busy = (state == RUN);
  assign last = (idx == CNT_W'(DIGITS - 1));

  // Operand digit check is done once at start on the live inputs.
  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      inv_in = inv_in | (a_p[i] > 4'd9) | (b_p[i] > 4'd9);
  end

  // Digit select by compare so the counter width never has to match the array.
  always_comb begin
    a_d = 4'd0;
    b_d = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == CNT_W'(i)) begin
        a_d = a_q[i];
        b_d = b_q[i];
      end
  end

  bcd_digit_add u_dig (
    .a     (a_d),
    .b     (b_d),
    .sub   (sub_q),
    .cin   (c_q),
    .digit (dig),
    .cout  (dig_c)
  );

  // Shadow with the current digit merged, so the completion edge can commit
  // the final digit together with the rest.
  always_comb begin
    shadow_nx = shadow;
    for (int i = 0; i < DIGITS; i++)
      if (idx == CNT_W'(i)) shadow_nx[i] = dig;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a_q     <= '0;
      b_q     <= '0;
      shadow  <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      inv_q   <= 1'b0;
      idx     <= '0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_q   <= a_p;
          b_q   <= b_p;
          sub_q <= sub;
          c_q   <= sub ^ cin;   // subtract: borrow-in becomes inverted carry-in
          inv_q <= inv_in;
          idx   <= '0;
        end
      end else begin
        shadow <= shadow_nx;
        c_q    <= dig_c;
        idx    <= idx + CNT_W'(1);
        if (last) begin
          done    <= 1'b1;
          invalid <= inv_q;
          if (inv_q) begin
            sum  <= '0;
            cout <= 1'b0;
          end else begin
            sum  <= shadow_nx;
            cout <= dig_c;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, invalid;
  logic [15:0] sum;

  int n_chk = 0;
  int n_fail = 0;

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .invalid(invalid)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full operation: start accepted at first edge, done after 4 more edges.
  // Operands are scrambled during RUN to show they were latched.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic cv,
                        input logic [15:0] es, input logic ec, input logic ei);
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    step();
    start = 1'b0;
    a = 16'h7777; b = 16'h3333; sub = ~sv; cin = ~cv;
    for (int i = 0; i < 3; i++) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " early done"}, done, 0);
      step();
    end
    check({tag, " busy4"}, busy, 1);
    step();
    check({tag, " done"}, done, 1);
    check({tag, " busy off"}, busy, 0);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " invalid"}, invalid, ei);
  endtask

  initial begin
    #2;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
    check("rst invalid", invalid, 0);
    #10 Rst = 1'b0;
    step();

    run_op("add1",  16'h1234, 16'h8766, 0, 0, 16'h0000, 1, 0);
    step();
    check("done pulse", done, 0);
    check("sum hold", sum, 16'h0000);
    run_op("ripple1", 16'h0999, 16'h0001, 0, 0, 16'h1000, 0, 0);
    run_op("ripple2", 16'h9999, 16'h0000, 0, 1, 16'h0000, 1, 0);
    run_op("sub1",  16'h5000, 16'h1234, 1, 0, 16'h3766, 1, 0);
    run_op("sub2",  16'h0100, 16'h0200, 1, 0, 16'h9900, 0, 0);
    run_op("sub3",  16'h0000, 16'h0000, 1, 1, 16'h9999, 0, 0);
    run_op("inv",   16'h12A4, 16'h0001, 0, 0, 16'h0000, 0, 1);
    run_op("invb",  16'h0001, 16'h00F0, 1, 0, 16'h0000, 0, 1);
    run_op("postinv", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0);

    // Start during RUN is ignored.
    a = 16'h1111; b = 16'h2222; sub = 0; cin = 0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 16'h4444; b = 16'h4444; start = 1'b1;
    step();
    start = 1'b0;
    check("ign busy", busy, 1);
    step();
    check("ign done", done, 1);
    check("ign sum", sum, 16'h3333);

    // Start in the done cycle is accepted; done 4 edges later, sum holds.
    a = 16'h0005; b = 16'h0004; sub = 0; cin = 0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b2b busy", busy, 1);
      check("b2b no done", done, 0);
      check("b2b sum hold", sum, 16'h3333);
      step();
    end
    step();
    check("b2b done", done, 1);
    check("b2b sum", sum, 16'h0009);
    step();
    check("b2b no extra done", done, 0);

    // Async reset in the third RUN cycle.
    run_op("prerst", 16'h0500, 16'h0600, 0, 1, 16'h1101, 0, 0);
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 Rst = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst sum", sum, 0);
    check("mid rst cout", cout, 0);
    check("mid rst invalid", invalid, 0);
    #1 Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("no done after rst", done, 0);
    end
    run_op("afterrst", 16'h2468, 16'h1357, 0, 0, 16'h3825, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
